// File: rtl/mvt_stream_engine.sv
// mvt_stream_engine: streaming x = A*y / x = A^T*y engine.
// A arrives once, row-major; the mode only selects which buffer entry a
// beat accumulates into, so no transposed copy of A is ever needed.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; buffer holds the previous job's results
// LOAD   | accepting A/y beats, one multiply-accumulate per beat
// DRAIN  | streaming buf[0..N-1] out over the valid/ready handshake
module mvt_stream_engine #(
    parameter int DW   = 32,
    parameter int ACCW = 64,
    parameter int N    = 100,
    localparam int IW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_a,
    input  logic [DW-1:0]   in_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_data,
    output logic [IW-1:0]   out_idx,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t          state_q, state_d;
    logic            mode_q;
    logic [IW-1:0]   row_q, col_q, k_q;
    logic [ACCW-1:0] acc_buf [N];
    logic            done_q;

    logic            beat;
    logic            start_ok;
    logic            out_hs;
    logic [IW-1:0]   tgt;
    logic [2*DW-1:0] prod;

    assign start_ok = (state_q == S_IDLE) && start;
    assign beat     = (state_q == S_LOAD) && in_valid;
    assign out_hs   = (state_q == S_DRAIN) && out_ready;
    // Mode 1 sends A[i][j]*y[i] to x[j]: that is the transpose product.
    assign tgt      = mode_q ? col_q : row_q;
    assign prod     = (2*DW)'(in_a) * (2*DW)'(in_y);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && row_q == LAST && col_q == LAST) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready && k_q == LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result port reads the drain pointer directly; held quiet outside DRAIN
    always_comb begin
        out_data = '0;
        out_idx  = '0;
        out_last = 1'b0;
        if (state_q == S_DRAIN) begin
            out_data = acc_buf[k_q];
            out_idx  = k_q;
            out_last = (k_q == LAST);
        end
    end

    // Mode latch, row/column beat counters and drain pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            row_q  <= '0;
            col_q  <= '0;
            k_q    <= '0;
        end else if (start_ok) begin
            mode_q <= mode;
            row_q  <= '0;
            col_q  <= '0;
            k_q    <= '0;
        end else if (beat) begin
            if (col_q == LAST) begin
                col_q <= '0;
                row_q <= (row_q == LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end else if (out_hs) begin
            k_q <= (k_q == LAST) ? '0 : k_q + 1'b1;
        end
    end

    // Accumulator buffer: single-cycle read-modify-write, so back-to-back
    // beats to the same entry need no forwarding or stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N; n++) acc_buf[n] <= '0;
        end else if (start_ok) begin
            for (int n = 0; n < N; n++) acc_buf[n] <= '0;
        end else if (beat) begin
            acc_buf[tgt] <= acc_buf[tgt] + ACCW'(prod);
        end
    end

    // done pulses in the cycle after the final result handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= out_hs && (k_q == LAST);
    end

    assign done = done_q;

endmodule

// File: tb/tb_mvt_stream_engine.sv
// tb_mvt_stream_engine: directed job table for a 4x4 engine plus reset and
// stray-start sequences. Inputs change and outputs are sampled on negedge.
module tb_mvt_stream_engine;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_y = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    int vecs = 0;
    int errs = 0;

    mvt_stream_engine #(.DW(32), .ACCW(64), .N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        bit                mode;
        bit                ones;
        bit                bubbles;
        bit                stalls;
        bit                poke;
        logic [3:0][63:0]  exp;
    } job_t;

    job_t jobs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " out_data"}, out_data, 64'd0);
        chk({tag, " out_idx"}, 64'(out_idx), 64'd0);
        chk({tag, " out_last"}, 64'(out_last), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
    endtask

    // Drives one beat for element index b (row-major) of job jb
    task automatic drive_beat(input job_t jb, input int b);
        int ii, jj;
        ii = b / N;
        jj = b % N;
        in_valid = 1'b1;
        in_a = jb.ones ? 32'hFFFF_FFFF : 32'(4 * ii + jj);
        in_y = jb.ones ? 32'hFFFF_FFFF : (jb.mode ? 32'(ii) : 32'(jj));
    endtask

    task automatic run_job(input job_t jb);
        int e, cyc, nb;
        bit stalled, poked;
        logic [63:0] prev_data;
        logic [1:0]  prev_idx;

        @(negedge clk);
        start = 1'b1;
        mode  = jb.mode;
        @(negedge clk);
        start = 1'b0;
        mode  = ~jb.mode;
        chk({jb.name, " busy after start"}, 64'(busy), 64'd1);
        chk({jb.name, " in_ready after start"}, 64'(in_ready), 64'd1);

        for (int b = 0; b < N * N; b++) begin
            nb = 0;
            while (jb.bubbles && nb < 6 && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(negedge clk);
                nb++;
            end
            chk({jb.name, " in_ready in load"}, 64'(in_ready), 64'd1);
            drive_beat(jb, b);
            if (jb.poke && b == 5) begin
                start = 1'b1;
                mode  = ~jb.mode;
            end
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;

        chk({jb.name, " out_valid after last beat"}, 64'(out_valid), 64'd1);
        chk({jb.name, " in_ready after last beat"}, 64'(in_ready), 64'd0);

        e = 0;
        cyc = 0;
        stalled = 0;
        poked = 0;
        prev_data = '0;
        prev_idx = '0;
        while (e < N && cyc < 100) begin
            out_ready = jb.stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (jb.poke && e == 1 && !poked) begin
                start = 1'b1;
                mode  = ~jb.mode;
                poked = 1;
            end
            chk({jb.name, " out_valid"}, 64'(out_valid), 64'd1);
            chk({jb.name, " in_ready in drain"}, 64'(in_ready), 64'd0);
            chk({jb.name, " out_idx"}, 64'(out_idx), 64'(e));
            chk({jb.name, " out_data"}, out_data, jb.exp[e]);
            chk({jb.name, " out_last"}, 64'(out_last), 64'(e == N - 1));
            chk({jb.name, " done in drain"}, 64'(done), 64'd0);
            if (stalled) begin
                chk({jb.name, " stall data stable"}, out_data, prev_data);
                chk({jb.name, " stall idx stable"}, 64'(out_idx), 64'(prev_idx));
            end
            prev_data = out_data;
            prev_idx  = out_idx;
            stalled   = !out_ready;
            if (out_ready) e++;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (e < N) chk({jb.name, " drain timeout"}, 64'(e), 64'(N));
        out_ready = 1'b0;
        chk({jb.name, " done pulse"}, 64'(done), 64'd1);
        chk({jb.name, " busy at done"}, 64'(busy), 64'd0);
        chk({jb.name, " out_valid at done"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({jb.name, " done single"}, 64'(done), 64'd0);
    endtask

    initial begin
        jobs[0] = '{"m0 plain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    {64'd86, 64'd62, 64'd38, 64'd14}};
        jobs[1] = '{"m1 plain", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    {64'd74, 64'd68, 64'd62, 64'd56}};
        jobs[2] = '{"m0 back-to-back", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    {64'd86, 64'd62, 64'd38, 64'd14}};
        jobs[3] = '{"m0 bubbles+stalls", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                    {64'd86, 64'd62, 64'd38, 64'd14}};
        jobs[4] = '{"m0 all-ones wrap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                    {64'hFFFF_FFF8_0000_0004, 64'hFFFF_FFF8_0000_0004,
                     64'hFFFF_FFF8_0000_0004, 64'hFFFF_FFF8_0000_0004}};
        jobs[5] = '{"m1 bubbles+stalls", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                    {64'd74, 64'd68, 64'd62, 64'd56}};
        jobs[6] = '{"m0 stray start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                    {64'd86, 64'd62, 64'd38, 64'd14}};

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        for (int t = 0; t < 7; t++) run_job(jobs[t]);

        // Abort a job after 7 beats with a mid-load reset
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 7; b++) begin
            drive_beat(jobs[0], b);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid-job reset");
        rst = 1'b0;
        run_job(jobs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
